ring_dec: RTL

- Receive-side companion to the one-hot ring counter: samples a ring code every clock and decodes it.
- Outputs the binary index and locks onto the expected rotation sequence.
- Counts completed laps and flags illegal or out-of-sequence codes.
- Sits downstream of a ring counter as a sequence decoder and health monitor for timing and step-signal generation.

---
 rtl/ring_dec.sv | 135 +++++++++++++
 1 files changed

// File: rtl/ring_dec.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ring_dec: one-hot ring code decoder, sequence lock and lap count  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module ring_dec #(
  parameter int N        = 4,
  parameter int IW       = 2,
  parameter int LOCK_CNT = 3,
  parameter int LAPW     = 8,
  parameter int EW       = 8
) (
  input  logic            ck,
  input  logic            res,
  input  logic [N-1:0]    q_in,
  output logic [IW-1:0]   idx,
  output logic            valid,
  output logic            locked,
  output logic            err,
  output logic [LAPW-1:0] lap,
  output logic [EW-1:0]   err_cnt
);

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    cur_q, cur_d;
  logic [N-1:0]    prv_q, prv_d;
  logic [3:0]      adv_cnt_q, adv_cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic [LAPW-1:0] lap_q, lap_d;
  logic [EW-1:0]   err_cnt_q, err_cnt_d;

  logic            w_legal;
  logic            w_adv;
  logic            w_wrap;
  logic [N-1:0]    w_rot;
  logic [IW-1:0]   w_enc;
  logic [3:0]      w_adv_inc;

  always_comb begin
    w_legal   = (cur_q != '0) && ((cur_q & (cur_q - N'(1))) == '0);
    w_rot     = {prv_q[N-2:0], prv_q[N-1]};
    w_adv     = w_legal && (cur_q == w_rot);
    w_wrap    = prv_q[N-1] && cur_q[0];
    w_adv_inc = adv_cnt_q + 4'd1;
    w_enc     = '0;
    for (int i = 0; i < N; i++) begin
      if (cur_q[i]) w_enc = IW'(i);
    end
  end

  always_comb begin
    cur_d     = q_in;
    prv_d     = cur_q;
    state_d   = state_q;
    adv_cnt_d = adv_cnt_q;
    idx_d     = idx_q;
    valid_d   = w_legal;
    err_d     = 1'b0;
    lap_d     = lap_q;
    err_cnt_d = err_cnt_q;

    // idx holds its last value across illegal codes
    if (w_legal) idx_d = w_enc;

    case (state_q)
      HUNT: begin
        if (w_adv) begin
          if (w_adv_inc == 4'(LOCK_CNT)) begin
            state_d   = LOCK;
            adv_cnt_d = '0;
            lap_d     = '0;
          end else begin
            adv_cnt_d = w_adv_inc;
          end
        end else begin
          adv_cnt_d = '0;
        end
      end
      LOCK: begin
        if (w_adv) begin
          if (w_wrap) lap_d = lap_q + LAPW'(1);
        end else begin
          err_d     = 1'b1;
          state_d   = HUNT;
          adv_cnt_d = '0;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + EW'(1);
        end
      end
      default: begin
        state_d   = HUNT;
        adv_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge ck) begin
    if (!res) begin
      state_q   <= HUNT;
      cur_q     <= '0;
      prv_q     <= '0;
      adv_cnt_q <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      lap_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      prv_q     <= prv_d;
      adv_cnt_q <= adv_cnt_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      lap_q     <= lap_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign idx     = idx_q;
  assign valid   = valid_q;
  assign locked  = (state_q == LOCK);
  assign err     = err_q;
  assign lap     = lap_q;
  assign err_cnt = err_cnt_q;

endmodule
`default_nettype wire
